// File: rtl/trigger_chain_core_pkg.sv
// Shared constants and arithmetic helpers for the trigger chain front end.
// Coefficient slot map, write sequence lengths, product and round/saturate.
package trigger_chain_pkg;

    localparam int NSAMP   = 8;
    localparam int NBITS   = 12;
    localparam int COEFF_W = 18;
    localparam int FRAC    = 14;
    localparam int PROD_W  = COEFF_W + NBITS;
    localparam int SUM_W   = 32;
    localparam int NOFF    = 7;
    localparam int NSLOT   = 25;
    localparam int SLOT_B  = 0;
    localparam int SLOT_A  = 1;

    localparam logic [6:0] OFF_UPDATE = 7'h00;
    localparam logic [6:0] OFF_BA     = 7'h04;
    localparam logic [6:0] OFF_C      = 7'h08;
    localparam logic [6:0] OFF_AP     = 7'h0C;
    localparam logic [6:0] OFF_D      = 7'h10;
    localparam logic [6:0] OFF_E      = 7'h14;
    localparam logic [6:0] OFF_DFG    = 7'h18;
    localparam logic [6:0] OFF_EGF    = 7'h1C;

    localparam logic signed [SUM_W-1:0] RND  = SUM_W'(2**(FRAC-1));
    localparam logic signed [SUM_W-1:0] YMAX = SUM_W'(2**(NBITS-1)-1);
    localparam logic signed [SUM_W-1:0] YMIN = -YMAX - 1;

    // Last pointer value per offset; counts are {2,4,2,7,8,1,1}.
    function automatic logic [2:0] wr_last(input logic [2:0] idx);
        case (idx)
            3'd0:    return 3'd1;
            3'd1:    return 3'd3;
            3'd2:    return 3'd1;
            3'd3:    return 3'd6;
            3'd4:    return 3'd7;
            default: return 3'd0;
        endcase
    endfunction

    function automatic logic [4:0] wr_base(input logic [2:0] idx);
        case (idx)
            3'd0:    return 5'd0;
            3'd1:    return 5'd2;
            3'd2:    return 5'd6;
            3'd3:    return 5'd8;
            3'd4:    return 5'd15;
            3'd5:    return 5'd23;
            3'd6:    return 5'd24;
            default: return 5'd0;
        endcase
    endfunction

    function automatic logic signed [PROD_W-1:0] mul(
        input logic signed [COEFF_W-1:0] c,
        input logic signed [NBITS-1:0]   s
    );
        logic signed [PROD_W-1:0] cw;
        logic signed [PROD_W-1:0] sw;
        cw = PROD_W'(c);
        sw = PROD_W'(s);
        return cw * sw;
    endfunction

    function automatic logic signed [NBITS-1:0] round_sat(
        input logic signed [SUM_W-1:0] s
    );
        logic signed [SUM_W-1:0] r;
        r = (s + RND) >>> FRAC;
        if (r > YMAX)
            r = YMAX;
        else if (r < YMIN)
            r = YMIN;
        return r[NBITS-1:0];
    endfunction

endpackage

// File: rtl/trigger_chain_core_if.sv
// Wishbone classic slave bundle for the coefficient register bank.
// Signal names follow the slave-side Wishbone naming.
interface trigger_chain_core_if;

    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_we_i;
    logic [3:0]  wb_sel_i;
    logic [7:0]  wb_adr_i;
    logic [31:0] wb_dat_i;
    logic        wb_ack_o;
    logic        wb_err_o;
    logic        wb_rty_o;
    logic [31:0] wb_dat_o;

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i,
        input  wb_sel_i, wb_adr_i, wb_dat_i,
        output wb_ack_o, wb_err_o, wb_rty_o,
        output wb_dat_o
    );

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i,
        output wb_sel_i, wb_adr_i, wb_dat_i,
        input  wb_ack_o, wb_err_o, wb_rty_o,
        input  wb_dat_o
    );

endinterface

// File: rtl/trigger_chain_core_notch.sv
// One 8-lane FIR notch stage: B*x[n] + A*x[n-1] + B*x[n-2].
// Cycle 1 registers the sum, cycle 2 registers the rounded result.
module notch_stage
    import trigger_chain_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clr,
    input  logic signed [COEFF_W-1:0] coef_b,
    input  logic signed [COEFF_W-1:0] coef_a,
    input  logic [NSAMP*NBITS-1:0]    x,
    output logic [NSAMP*NBITS-1:0]    y
);

    // xs[0..1] hold lanes 6,7 of the previous word; xs[i+2] is lane i.
    logic signed [NBITS-1:0] xs [NSAMP+2];
    logic signed [NBITS-1:0] h1_q;
    logic signed [NBITS-1:0] h2_q;
    logic signed [SUM_W-1:0] sum [NSAMP];
    logic signed [SUM_W-1:0] sum_q [NSAMP];

    always_comb begin
        xs[0] = h2_q;
        xs[1] = h1_q;
        for (int i = 0; i < NSAMP; i++)
            xs[i+2] = x[i*NBITS +: NBITS];
        for (int i = 0; i < NSAMP; i++)
            sum[i] = SUM_W'(mul(coef_b, xs[i+2]))
                   + SUM_W'(mul(coef_a, xs[i+1]))
                   + SUM_W'(mul(coef_b, xs[i]));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h1_q <= '0;
            h2_q <= '0;
            y    <= '0;
            for (int i = 0; i < NSAMP; i++)
                sum_q[i] <= '0;
        end else if (clr) begin
            h1_q <= '0;
            h2_q <= '0;
            y    <= '0;
            for (int i = 0; i < NSAMP; i++)
                sum_q[i] <= '0;
        end else begin
            h1_q <= xs[NSAMP+1];
            h2_q <= xs[NSAMP];
            for (int i = 0; i < NSAMP; i++) begin
                sum_q[i] <= sum[i];
                y[i*NBITS +: NBITS] <= round_sat(sum_q[i]);
            end
        end
    end

endmodule

// File: rtl/trigger_chain_core.sv
// Trigger path front end: Wishbone coefficient bank with shadow/active
// sets feeding two cascaded notch stages.
module trigger_chain_core
    import trigger_chain_pkg::*;
(
    input  logic                   aclk,
    input  logic                   wb_rst_i,
    trigger_chain_core_if.slave    wb,
    input  logic                   reset_BQ_i,
    input  logic [NSAMP*NBITS-1:0] dat_i,
    output logic [NSAMP*NBITS-1:0] dat_o,
    output logic [NSAMP*NBITS-1:0] probes
);

    logic signed [COEFF_W-1:0] shd_q [2][NSLOT];
    logic signed [COEFF_W-1:0] act_q [2][NSLOT];
    logic [2:0]                ptr_q [2][NOFF];
    logic                      ack_q;

    logic [6:0] off;
    logic       stg;
    logic       wr;
    logic       hit;
    logic       upd;
    logic [2:0] idx;
    logic [4:0] slot;

    assign wb.wb_ack_o = ack_q;
    assign wb.wb_err_o = 1'b0;
    assign wb.wb_rty_o = 1'b0;
    assign wb.wb_dat_o = '0;

    always_comb begin
        off  = wb.wb_adr_i[6:0];
        stg  = wb.wb_adr_i[7];
        wr   = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q & wb.wb_we_i;
        hit  = 1'b1;
        idx  = '0;
        unique case (1'b1)
            off == OFF_BA:  idx = 3'd0;
            off == OFF_C:   idx = 3'd1;
            off == OFF_AP:  idx = 3'd2;
            off == OFF_D:   idx = 3'd3;
            off == OFF_E:   idx = 3'd4;
            off == OFF_DFG: idx = 3'd5;
            off == OFF_EGF: idx = 3'd6;
            default:        hit = 1'b0;
        endcase
        upd  = wr & (off == OFF_UPDATE) & wb.wb_dat_i[0];
        slot = wr_base(idx) + {2'b00, ptr_q[stg][idx]};
    end

    always_ff @(posedge aclk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ack_q <= 1'b0;
            for (int s = 0; s < 2; s++) begin
                for (int k = 0; k < NSLOT; k++) begin
                    shd_q[s][k] <= '0;
                    act_q[s][k] <= '0;
                end
                for (int j = 0; j < NOFF; j++)
                    ptr_q[s][j] <= '0;
            end
        end else begin
            ack_q <= wb.wb_cyc_i & wb.wb_stb_i & ~ack_q;
            if (wr && hit) begin
                shd_q[stg][slot] <= wb.wb_dat_i[COEFF_W-1:0];
                if (ptr_q[stg][idx] == wr_last(idx))
                    ptr_q[stg][idx] <= '0;
                else
                    ptr_q[stg][idx] <= ptr_q[stg][idx] + 3'd1;
            end
            if (upd) begin
                for (int k = 0; k < NSLOT; k++)
                    act_q[stg][k] <= shd_q[stg][k];
                for (int j = 0; j < NOFF; j++)
                    ptr_q[stg][j] <= '0;
            end
        end
    end

    notch_stage u_s0 (
        .clk    (aclk),
        .rst    (wb_rst_i),
        .clr    (reset_BQ_i),
        .coef_b (act_q[0][SLOT_B]),
        .coef_a (act_q[0][SLOT_A]),
        .x      (dat_i),
        .y      (probes)
    );

    notch_stage u_s1 (
        .clk    (aclk),
        .rst    (wb_rst_i),
        .clr    (reset_BQ_i),
        .coef_b (act_q[1][SLOT_B]),
        .coef_a (act_q[1][SLOT_A]),
        .x      (probes),
        .y      (dat_o)
    );

endmodule

// File: tb/tb_trigger_chain_core.sv
// Directed bench for trigger_chain_core: Wishbone loads, filter response,
// saturation, shadow/update behaviour and filter-state clear.
module tb_trigger_chain_core;
    import trigger_chain_pkg::*;

    logic        aclk;
    logic        wb_rst_i;
    logic        reset_BQ_i;
    logic [95:0] dat_i;
    logic [95:0] dat_o;
    logic [95:0] probes;
    logic [95:0] ramp;
    logic [95:0] p_imp;
    logic [95:0] d_imp;
    int          n_chk;
    int          n_pass;

    trigger_chain_core_if wb ();

    trigger_chain_core dut (
        .aclk       (aclk),
        .wb_rst_i   (wb_rst_i),
        .wb         (wb.slave),
        .reset_BQ_i (reset_BQ_i),
        .dat_i      (dat_i),
        .dat_o      (dat_o),
        .probes     (probes)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [95:0] got,
                       input logic [95:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    function automatic logic [95:0] lv(input int idx, input int val);
        logic [95:0] r;
        logic [31:0] v;
        r = '0;
        v = val;
        r[idx*12 +: 12] = v[11:0];
        return r;
    endfunction

    task automatic run_word(input logic [95:0] w);
        dat_i = w;
        @(posedge aclk);
        #1;
    endtask

    task automatic flush(input int n);
        repeat (n) run_word('0);
    endtask

    task automatic wb_xfer(input logic we, input logic [7:0] adr,
                           input logic [31:0] d, output logic [31:0] rd);
        int n;
        n  = 0;
        rd = 32'hdead_beef;
        wb.wb_cyc_i = 1'b1;
        wb.wb_stb_i = 1'b1;
        wb.wb_we_i  = we;
        wb.wb_adr_i = adr;
        wb.wb_dat_i = d;
        for (int i = 0; i < 2 && n == 0; i++) begin
            @(posedge aclk);
            #1;
            if (wb.wb_ack_o) begin
                n++;
                rd = wb.wb_dat_o;
            end
        end
        wb.wb_cyc_i = 1'b0;
        wb.wb_stb_i = 1'b0;
        wb.wb_we_i  = 1'b0;
        @(posedge aclk);
        #1;
        if (wb.wb_ack_o)
            n++;
        chk("wb_ack", 96'(n), 96'd1);
    endtask

    task automatic wb_wr(input logic [7:0] adr, input int d);
        logic [31:0] rd;
        wb_xfer(1'b1, adr, d, rd);
    endtask

    task automatic set_bq(input logic s, input int b, input int a);
        wb_wr({s, OFF_BA}, b);
        wb_wr({s, OFF_BA}, a);
        wb_wr({s, OFF_UPDATE}, 1);
    endtask

    // Lane-0 impulse of 512 through stage 0, checked on probes.
    task automatic imp_probe(input string tag, input logic [95:0] exp);
        flush(3);
        run_word(lv(0, 512));
        run_word('0);
        chk(tag, probes, exp);
    endtask

    initial begin
        logic [31:0] rd;
        int          bad;
        n_chk  = 0;
        n_pass = 0;
        ramp   = '0;
        for (int i = 0; i < 8; i++)
            ramp |= lv(i, i + 1);
        p_imp = lv(0, 256) | lv(1, -256) | lv(2, 256);
        d_imp = lv(0, 256) | lv(1, -256) | lv(2, 512)
              | lv(3, -256) | lv(4, 256);
        wb_rst_i    = 1'b1;
        reset_BQ_i  = 1'b0;
        dat_i       = '0;
        wb.wb_cyc_i = 1'b0;
        wb.wb_stb_i = 1'b0;
        wb.wb_we_i  = 1'b0;
        wb.wb_sel_i = 4'hf;
        wb.wb_adr_i = '0;
        wb.wb_dat_i = '0;
        repeat (3) @(posedge aclk);
        #1;
        wb_rst_i = 1'b0;

        chk("rst_probes", probes, '0);
        chk("rst_dat_o", dat_o, '0);
        chk("rst_ack", 96'(wb.wb_ack_o), '0);
        chk("err_rty", 96'({wb.wb_err_o, wb.wb_rty_o}), '0);

        run_word(ramp);
        run_word('0);
        chk("zero_coef", probes, '0);

        set_bq(1'b0, 16384, 0);
        set_bq(1'b1, 16384, 0);
        flush(4);
        run_word(ramp);
        run_word('0);
        chk("unit_p0", probes, lv(0, 1) | lv(1, 2) | lv(2, 4)
            | lv(3, 6) | lv(4, 8) | lv(5, 10) | lv(6, 12) | lv(7, 14));
        run_word('0);
        chk("unit_p1", probes, lv(0, 7) | lv(1, 8));
        run_word('0);
        chk("unit_d0", dat_o, lv(0, 1) | lv(1, 2) | lv(2, 5)
            | lv(3, 8) | lv(4, 12) | lv(5, 16) | lv(6, 20) | lv(7, 24));
        run_word('0);
        chk("unit_d1", dat_o, lv(0, 19) | lv(1, 22) | lv(2, 7) | lv(3, 8));

        set_bq(1'b0, 8192, -8192);
        flush(4);
        run_word(lv(0, 512));
        run_word('0);
        chk("imp0_p", probes, p_imp);
        run_word('0);
        chk("imp0_tail", probes, '0);
        run_word('0);
        chk("imp0_d", dat_o, d_imp);
        run_word('0);
        chk("imp0_dtail", dat_o, '0);

        flush(4);
        run_word(lv(7, 512));
        run_word('0);
        chk("imp7_p0", probes, lv(7, 256));
        run_word('0);
        chk("imp7_p1", probes, lv(0, -256) | lv(1, 256));

        set_bq(1'b0, 65536, 0);
        flush(4);
        run_word(lv(0, 2047) | lv(3, -2048) | lv(6, 600));
        run_word('0);
        chk("sat_p0", probes, lv(0, 2047) | lv(2, 2047)
            | lv(3, -2048) | lv(5, -2048) | lv(6, 2047));
        run_word('0);
        chk("sat_p1", probes, lv(0, 2047));

        set_bq(1'b0, 8192, 0);
        imp_probe("half_gain", lv(0, 256) | lv(2, 256));
        wb_wr({1'b0, OFF_BA}, 16384);
        imp_probe("shadow_hold", lv(0, 256) | lv(2, 256));
        wb_wr({1'b0, OFF_BA}, 0);
        wb_wr({1'b0, OFF_UPDATE}, 1);
        imp_probe("upd_new", lv(0, 512) | lv(2, 512));
        wb_wr({1'b0, OFF_BA}, 4096);
        wb_wr({1'b0, OFF_BA}, 0);
        wb_wr({1'b0, OFF_BA}, 32768);
        wb_wr({1'b0, OFF_UPDATE}, 1);
        imp_probe("ptr_wrap", lv(0, 1024) | lv(2, 1024));
        wb_wr({1'b0, OFF_BA}, 4096);
        wb_wr({1'b0, OFF_BA}, 0);
        wb_wr({1'b0, OFF_UPDATE}, 0);
        imp_probe("upd_zero", lv(0, 1024) | lv(2, 1024));
        wb_wr(8'h24, 123);
        wb_wr({1'b0, OFF_C}, 777);
        wb_xfer(1'b0, {1'b0, OFF_BA}, 32'h5555_5555, rd);
        chk("rd_data", 96'(rd), '0);
        wb_wr({1'b0, OFF_UPDATE}, 1);
        imp_probe("upd_after", lv(0, 128) | lv(2, 128));

        wb_wr({1'b0, OFF_BA}, 32768);
        wb_wr({1'b0, OFF_BA}, 0);
        flush(3);
        dat_i       = lv(0, 512);
        wb.wb_cyc_i = 1'b1;
        wb.wb_stb_i = 1'b1;
        wb.wb_we_i  = 1'b1;
        wb.wb_adr_i = {1'b0, OFF_UPDATE};
        wb.wb_dat_i = 32'd1;
        @(posedge aclk);
        #1;
        chk("bnd_ack", 96'(wb.wb_ack_o), 96'd1);
        wb.wb_cyc_i = 1'b0;
        wb.wb_stb_i = 1'b0;
        wb.wb_we_i  = 1'b0;
        run_word('0);
        chk("bnd_old", probes, lv(0, 128) | lv(2, 128));
        chk("bnd_ack_off", 96'(wb.wb_ack_o), '0);
        imp_probe("bnd_new", lv(0, 1024) | lv(2, 1024));

        set_bq(1'b0, 8192, -8192);
        flush(3);
        for (int i = 0; i < 4; i++)
            run_word(ramp);
        reset_BQ_i = 1'b1;
        bad = 0;
        for (int i = 0; i < 32; i++) begin
            run_word(ramp ^ 96'(i * 7));
            if (dat_o !== '0 || probes !== '0)
                bad++;
        end
        chk("bq_hold", 96'(bad), '0);
        reset_BQ_i = 1'b0;
        run_word(lv(0, 512));
        run_word('0);
        chk("bq_imp_p", probes, p_imp);
        run_word('0);
        run_word('0);
        chk("bq_imp_d", dat_o, d_imp);

        for (int i = 0; i < 3; i++)
            run_word(ramp);
        wb_rst_i = 1'b1;
        #1;
        chk("arst_probes", probes, '0);
        chk("arst_dat_o", dat_o, '0);
        @(posedge aclk);
        #1;
        wb_rst_i = 1'b0;
        run_word(ramp);
        run_word('0);
        chk("arst_coef", probes, '0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
